uart_rx: RTL

// - Receive half of the UART peripheral: deserialises rxd_i into 5..8-bit characters with parity,

---
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Receive-buffer side of the UART receiver: head entry, error flags, occupancy and pop.
// The master is the receiver; the slave is the register/interrupt logic that consumes entries.
interface uart_rx_if #(
    parameter int DEPTH = 16
);
    localparam int UW = $clog2(DEPTH) + 1;

    logic          rx_pop_i;
    logic [7:0]    rx_data_o;
    logic          rx_pe_o;
    logic          rx_fe_o;
    logic          rx_bi_o;
    logic          rx_valid_o;
    logic [UW-1:0] rx_usage_o;
    logic          overrun_o;

    modport master (
        input  rx_pop_i,
        output rx_data_o, rx_pe_o, rx_fe_o, rx_bi_o, rx_valid_o, rx_usage_o, overrun_o
    );

    modport slave (
        output rx_pop_i,
        input  rx_data_o, rx_pe_o, rx_fe_o, rx_bi_o, rx_valid_o, rx_usage_o, overrun_o
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled deserialiser with parity/framing/break checks and a
// receive buffer that is either a DEPTH-entry FIFO or a single holding register.
//
// state   | meaning
// IDLE    | waiting for a 1->0 edge on the synchronised line
// START   | confirming the start bit at mid-bit (cnt==7)
// DATA    | sampling word-length data bits, LSB first
// PAR     | sampling the parity bit
// STOP    | sampling the first stop bit, pushing the entry
// BREAK   | line stuck low after a break; wait for it to return high
module uart_rx #(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       oversample_edge_i,
    input  logic       rxd_i,
    input  logic [1:0] word_len_i,
    input  logic       par_en_i,
    input  logic [1:0] par_sel_i,
    input  logic       fifo_en_i,
    input  logic       fifo_clr_i,
    output logic       rx_idle_o,
    uart_rx_if.master  rx_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int UW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       rxd_meta, rxd_s, rxd_d;
    logic       sample;
    logic [2:0] last_bit;
    logic       exp_par;
    logic       push;
    logic       ent_pe, ent_fe, ent_bi;

    // rxd_d holds the previous synchronised value for start-edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_d    <= 1'b1;
        end else begin
            rxd_meta <= rxd_i;
            rxd_s    <= rxd_meta;
            rxd_d    <= rxd_s;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    assign sample   = oversample_edge_i && (cnt_q == 4'd15);
    assign last_bit = {1'b0, word_len_i} + 3'd4;

    // Unused high data bits are zero, so a full-byte XOR gives the word parity
    always_comb begin
        exp_par = 1'b0;
        unique case (par_sel_i)
            2'b00:   exp_par = ~^shift_q;
            2'b01:   exp_par = ^shift_q;
            2'b10:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

    assign ent_pe = par_en_i && (par_q != exp_par);
    assign ent_fe = ~rxd_s;
    assign ent_bi = (shift_q == 8'd0) && (!par_en_i || !par_q) && !rxd_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        push    = 1'b0;
        if (oversample_edge_i) begin
            cnt_d = cnt_q + 4'd1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (rxd_d && !rxd_s) begin
                    state_d = S_START;
                    cnt_d   = 4'd0;
                end
            end
            S_START: begin
                if (oversample_edge_i && cnt_q == 4'd7) begin
                    if (!rxd_s) begin
                        state_d = S_DATA;
                        cnt_d   = 4'd0;
                        bit_d   = 3'd0;
                        shift_d = 8'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d[bit_q] = rxd_s;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == last_bit) begin
                        state_d = par_en_i ? S_PAR : S_STOP;
                    end
                end
            end
            S_PAR: begin
                if (sample) begin
                    par_d   = rxd_s;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    push    = 1'b1;
                    state_d = ent_bi ? S_BREAK : S_IDLE;
                end
            end
            S_BREAK: begin
                if (rxd_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rx_idle_o = (state_q == S_IDLE);

    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [UW-1:0] usage, cap;
    logic          fifo_en_q;
    logic          flush, full, pop_ok, push_ok;
    logic [10:0]   head;

    assign cap     = fifo_en_i ? UW'(DEPTH) : UW'(1);
    assign flush   = fifo_clr_i || (fifo_en_i != fifo_en_q);
    assign full    = (usage >= cap);
    assign pop_ok  = rx_if.rx_pop_i && (usage != '0);
    // A pop in the same cycle frees the slot before the push lands
    assign push_ok = push && (!full || pop_ok) && !flush;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_en_q <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            usage     <= '0;
        end else begin
            fifo_en_q <= fifo_en_i;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                usage  <= '0;
            end else begin
                if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (push_ok && !pop_ok) usage <= usage + UW'(1);
                else if (pop_ok && !push_ok) usage <= usage - UW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= {ent_bi, ent_fe, ent_pe, shift_q};
        end
    end

    assign head             = mem[rd_ptr];
    assign rx_if.rx_valid_o = (usage != '0);
    assign rx_if.rx_usage_o = usage;
    assign rx_if.rx_data_o  = rx_if.rx_valid_o ? head[7:0] : 8'd0;
    assign rx_if.rx_pe_o    = rx_if.rx_valid_o && head[8];
    assign rx_if.rx_fe_o    = rx_if.rx_valid_o && head[9];
    assign rx_if.rx_bi_o    = rx_if.rx_valid_o && head[10];
    assign rx_if.overrun_o  = push && full && !pop_ok && !flush;
endmodule
